// File: rtl/exec_mul_sequencer.sv
// Multi-cycle radix-2 shift-add multiplier with sequencing FSM for the execute stage.
// Optional build macro MUL_EARLY_OUT_EN: finish as soon as the remaining multiplier bits are zero.
module exec_mul_sequencer #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [XLEN-1:0] operand_A,
   input  logic [XLEN-1:0] operand_B,
   input  logic            flush,
   output logic            stall,
   output logic            resp_valid,
   output logic [XLEN-1:0] mul_result
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

   state_t            state_q, state_d;
   logic [XLEN-1:0]   mcand_q, mcand_d;
   logic [XLEN-1:0]   mplier_q, mplier_d;
   logic [XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]   mul_result_q, mul_result_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              last_step;

   always_comb begin
      state_d      = state_q;
      mcand_d      = mcand_q;
      mplier_d     = mplier_q;
      acc_d        = acc_q;
      count_d      = count_q;
      mul_result_d = mul_result_q;
      req_ready    = (state_q == S_IDLE);
      stall        = 1'b0;
      resp_valid   = 1'b0;
      last_step    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_valid && !flush) begin
               stall    = 1'b1;
               mcand_d  = operand_A;
               mplier_d = operand_B;
               acc_d    = '0;
               count_d  = '0;
               state_d  = S_RUN;
            end
         end

         S_RUN: begin
            stall = 1'b1;
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               if (mplier_q[0]) begin
                  acc_d = acc_q + mcand_q;
               end
               mcand_d   = mcand_q << 1;
               mplier_d  = mplier_q >> 1;
               count_d   = count_q + 1'b1;
               last_step = (count_q == LAST_CNT);
`ifdef MUL_EARLY_OUT_EN
               last_step = last_step || (mplier_d == '0);
`endif
               // Result is captured on entry to DONE so it is valid alongside resp_valid.
               if (last_step) begin
                  mul_result_d = acc_d;
                  state_d      = S_DONE;
               end
            end
         end

         S_DONE: begin
            resp_valid = 1'b1;
            state_d    = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         mcand_q      <= '0;
         mplier_q     <= '0;
         acc_q        <= '0;
         count_q      <= '0;
         mul_result_q <= '0;
      end else begin
         state_q      <= state_d;
         mcand_q      <= mcand_d;
         mplier_q     <= mplier_d;
         acc_q        <= acc_d;
         count_q      <= count_d;
         mul_result_q <= mul_result_d;
      end
   end

   assign mul_result = mul_result_q;

endmodule

// File: tb/tb_exec_mul_sequencer.sv
// Self-checking bench for exec_mul_sequencer: cycle-level latency/product model plus directed literals.
// Honours MUL_EARLY_OUT_EN when the same macro is defined for the bench.
module tb_exec_mul_sequencer;

`ifdef MUL_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] operand_A;
   logic [31:0] operand_B;
   logic        flush;
   logic        stall;
   logic        resp_valid;
   logic [31:0] mul_result;

   exec_mul_sequencer #(.XLEN(32), .CNT_W(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .operand_A  (operand_A),
      .operand_B  (operand_B),
      .flush      (flush),
      .stall      (stall),
      .resp_valid (resp_valid),
      .mul_result (mul_result)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors     = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Accept-to-response latency in cycles, from the operand_B value alone.
   function automatic int lat_of(input logic [31:0] b);
      if (!EARLY) return 33;
      for (int i = 31; i >= 0; i--) begin
         if (b[i]) return i + 2;
      end
      return 2;
   endfunction

   // Model: either idle, or busy until a known response cycle with a known product.
   bit          known = 1'b0;
   bit          busy  = 1'b0;
   int          resp_cyc;
   logic [31:0] exp_res;
   logic [31:0] held = '0;
   logic        e_ready, e_stall, e_resp;
   logic [31:0] e_res;

   always @(negedge clk) begin
      if (known) begin
         if (!busy) begin
            e_ready = 1'b1;
            e_stall = req_valid && !flush;
            e_resp  = 1'b0;
            e_res   = held;
         end else if (cyc == resp_cyc) begin
            e_ready = 1'b0;
            e_stall = 1'b0;
            e_resp  = 1'b1;
            e_res   = exp_res;
         end else begin
            e_ready = 1'b0;
            e_stall = 1'b1;
            e_resp  = 1'b0;
            e_res   = held;
         end
         chk("model req_ready",  32'(req_ready),  32'(e_ready));
         chk("model stall",      32'(stall),      32'(e_stall));
         chk("model resp_valid", 32'(resp_valid), 32'(e_resp));
         chk("model mul_result", mul_result,      e_res);
      end
      if (rst) begin
         known = 1'b1;
         busy  = 1'b0;
         held  = '0;
      end else if (known) begin
         if (!busy) begin
            if (req_valid && !flush) begin
               busy     = 1'b1;
               resp_cyc = cyc + lat_of(operand_B);
               exp_res  = 32'(64'(operand_A) * 64'(operand_B));
            end
         end else if (cyc == resp_cyc) begin
            busy = 1'b0;
            held = exp_res;
         end else if (flush) begin
            busy = 1'b0;
         end
      end
   end

   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] lit,
                         input int lat_lit, input string name);
      int t0;
      int stalls;
      bit got;
      @(posedge clk); #1;
      req_valid = 1'b1; operand_A = a; operand_B = b; t0 = cyc;
      @(negedge clk);
      stalls = stall ? 1 : 0;
      @(posedge clk); #1;
      req_valid = 1'b0; operand_A = $urandom; operand_B = $urandom;
      got = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (resp_valid) begin
            got = 1'b1;
            break;
         end
         if (stall) stalls++;
      end
      chk({name, " response seen"}, 32'(got), 32'd1);
      chk({name, " result"}, mul_result, lit);
      chk({name, " latency"}, 32'(cyc - t0), 32'(lat_lit));
      chk({name, " stall cycles"}, 32'(stalls), 32'(lat_lit));
   endtask

   task automatic chk_idle_outputs(input string name, input logic [31:0] res);
      chk({name, " req_ready"},  32'(req_ready),  32'd1);
      chk({name, " stall"},      32'(stall),      32'd0);
      chk({name, " resp_valid"}, 32'(resp_valid), 32'd0);
      chk({name, " mul_result"}, mul_result,      res);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, r1, r2, pulses;
      bit got;
      rst = 1'b1; req_valid = 1'b0; flush = 1'b0; operand_A = '0; operand_B = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_idle_outputs("reset", 32'd0);

      run_op(32'd3, 32'd5, 32'd15, EARLY ? 4 : 33, "3x5");
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, "ffffffff^2");
      run_op(32'h8000_0000, 32'd2, 32'h0000_0000, EARLY ? 3 : 33, "overflow");
      run_op(32'd0, 32'h1234, 32'd0, EARLY ? 14 : 33, "zero A");
      run_op(32'h55, 32'd0, 32'd0, EARLY ? 2 : 33, "zero B");
      run_op(32'd1234, 32'd1, 32'd1234, EARLY ? 2 : 33, "1234x1");
      run_op(32'd1, 32'h8000_0000, 32'h8000_0000, 33, "1 x msb");

      // flush while idle: no accept, no stall
      @(posedge clk); #1;
      req_valid = 1'b1; flush = 1'b1; operand_A = 32'd9; operand_B = 32'd9;
      @(negedge clk);
      chk("idle flush stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk_idle_outputs("after idle flush", 32'h8000_0000);

      // flush mid-run
      @(posedge clk); #1;
      req_valid = 1'b1; operand_A = 32'd7; operand_B = 32'd9; t0 = cyc;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat ((EARLY ? 2 : 10) - 1) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk_idle_outputs("after run flush", 32'h8000_0000);
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         if (resp_valid) pulses++;
      end
      chk("flush resp pulses", 32'(pulses), 32'd0);

      // reset mid-run
      @(posedge clk); #1;
      req_valid = 1'b1; operand_A = 32'd100; operand_B = 32'h0003_0000; t0 = cyc;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk_idle_outputs("after run reset", 32'd0);
      run_op(32'd6, 32'd7, 32'd42, EARLY ? 4 : 33, "6x7");

      // back-to-back with req_valid held high
      @(posedge clk); #1;
      req_valid = 1'b1; operand_A = 32'd2; operand_B = 32'd3; t0 = cyc;
      @(posedge clk); #1;
      operand_A = 32'd4; operand_B = 32'd5;
      got = 1'b0; r1 = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (resp_valid) begin got = 1'b1; r1 = cyc; break; end
      end
      chk("b2b first seen", 32'(got), 32'd1);
      chk("b2b first result", mul_result, 32'd6);
      chk("b2b first latency", 32'(r1 - t0), EARLY ? 32'd3 : 32'd33);
      @(posedge clk);
      got = 1'b0; r2 = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (resp_valid) begin got = 1'b1; r2 = cyc; break; end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("b2b second seen", 32'(got), 32'd1);
      chk("b2b second result", mul_result, 32'd20);
      chk("b2b gap", 32'(r2 - r1), EARLY ? 32'd5 : 32'd34);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
